// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, register-index width,
// memory-stage FSM states and a word-alignment helper.
package mips_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int REG_W      = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register. It holds its contents while en=0 (the stage is
// stalled) and loads a bubble when flush is raised on a load edge.
module ex_mem_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic [REG_W-1:0]  ex_write_reg,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_branch,
  input  logic [DATA_W-1:0] ex_branch_target,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_alu_result,
  output logic              m_zero,
  output logic [DATA_W-1:0] m_write_data,
  output logic [REG_W-1:0]  m_write_reg,
  output logic              m_reg_write,
  output logic              m_mem_to_reg,
  output logic              m_mem_read,
  output logic              m_mem_write,
  output logic              m_branch,
  output logic [DATA_W-1:0] m_branch_target
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid         <= 1'b0;
      m_alu_result    <= '0;
      m_zero          <= 1'b0;
      m_write_data    <= '0;
      m_write_reg     <= '0;
      m_reg_write     <= 1'b0;
      m_mem_to_reg    <= 1'b0;
      m_mem_read      <= 1'b0;
      m_mem_write     <= 1'b0;
      m_branch        <= 1'b0;
      m_branch_target <= '0;
    end else if (en) begin
      // Only the valid bit is killed on flush; the payload is don't-care.
      m_valid         <= ex_valid & ~flush;
      m_alu_result    <= ex_alu_result;
      m_zero          <= ex_zero;
      m_write_data    <= ex_write_data;
      m_write_reg     <= ex_write_reg;
      m_reg_write     <= ex_reg_write;
      m_mem_to_reg    <= ex_mem_to_reg;
      m_mem_read      <= ex_mem_read;
      m_mem_write     <= ex_mem_write;
      m_branch        <= ex_branch;
      m_branch_target <= ex_branch_target;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, req/ack data-memory FSM, branch resolve
// and MEM/WB register. Optional MEM_ALIGN_CHECK_EN adds misaligned trapping.
module mem_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic [REG_W-1:0]  ex_write_reg,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_branch,
  input  logic [DATA_W-1:0] ex_branch_target,
  input  logic              flush,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_read_data
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misaligned
`endif
);

  logic              m_valid, m_zero, m_reg_write, m_mem_to_reg;
  logic              m_mem_read, m_mem_write, m_branch;
  logic [DATA_W-1:0] m_alu_result, m_write_data, m_branch_target;
  logic [REG_W-1:0]  m_write_reg;

  mem_state_t state, state_nxt;
  logic       in_access, capture_mem, ex_aligned, m_misaligned;

  ex_mem_reg #(.DATA_W(DATA_W)) u_ex_mem (
    .clk              (clk),
    .reset            (reset),
    .en               (~stall),
    .flush            (flush),
    .ex_valid         (ex_valid),
    .ex_alu_result    (ex_alu_result),
    .ex_zero          (ex_zero),
    .ex_write_data    (ex_write_data),
    .ex_write_reg     (ex_write_reg),
    .ex_reg_write     (ex_reg_write),
    .ex_mem_to_reg    (ex_mem_to_reg),
    .ex_mem_read      (ex_mem_read),
    .ex_mem_write     (ex_mem_write),
    .ex_branch        (ex_branch),
    .ex_branch_target (ex_branch_target),
    .m_valid          (m_valid),
    .m_alu_result     (m_alu_result),
    .m_zero           (m_zero),
    .m_write_data     (m_write_data),
    .m_write_reg      (m_write_reg),
    .m_reg_write      (m_reg_write),
    .m_mem_to_reg     (m_mem_to_reg),
    .m_mem_read       (m_mem_read),
    .m_mem_write      (m_mem_write),
    .m_branch         (m_branch),
    .m_branch_target  (m_branch_target)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign ex_aligned   = word_aligned(ex_alu_result[1:0]);
  assign m_misaligned = m_valid & (m_mem_read | m_mem_write) & ~word_aligned(m_alu_result[1:0]);
  assign misaligned   = m_misaligned;
`else
  assign ex_aligned   = 1'b1;
  assign m_misaligned = 1'b0;
`endif

  // A memory instruction is decided on its way into EX/MEM, so the request
  // goes out in the very cycle the instruction sits in MEM.
  assign capture_mem = ex_valid & ~flush & (ex_mem_read | ex_mem_write) & ex_aligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_access = 1'b0;
    case (state)
      IDLE:   if (capture_mem) state_nxt = ACCESS;
      ACCESS: begin
        in_access = 1'b1;
        if (dm_ack) state_nxt = capture_mem ? ACCESS : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall         = in_access & ~dm_ack;
  assign dm_req        = in_access;
  assign dm_we         = in_access & m_mem_write;
  assign dm_addr       = m_alu_result[ADDR_W-1:0];
  assign dm_wdata      = m_write_data;
  assign pc_src        = m_valid & m_branch & m_zero;
  assign branch_target = m_branch_target;

  // MEM/WB: memory entries land only on the ack edge; everything else
  // (including trapped misaligned accesses) flows straight through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_write_reg  <= '0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
    end else if (in_access) begin
      if (dm_ack) begin
        wb_valid      <= 1'b1;
        wb_reg_write  <= m_reg_write & ~m_mem_write;
        wb_mem_to_reg <= m_mem_to_reg;
        wb_write_reg  <= m_write_reg;
        wb_alu_result <= m_alu_result;
        wb_read_data  <= dm_rdata;
      end else begin
        wb_valid <= 1'b0;
      end
    end else begin
      wb_valid      <= m_valid;
      wb_reg_write  <= m_reg_write & ~m_misaligned;
      wb_mem_to_reg <= m_mem_to_reg;
      wb_write_reg  <= m_write_reg;
      wb_alu_result <= m_alu_result;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, hand-written handshake
// corner cases and a randomized stream against a program-order reference model.
module tb_mem_stage;

  localparam logic [1:0] K_ALU = 2'd0, K_BR = 2'd1, K_LD = 2'd2, K_ST = 2'd3;
  localparam int NRAND = 300;

  typedef struct {
    logic        live;
    logic        valid;
    logic        flush;
    logic [1:0]  kind;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] tgt;
    logic [4:0]  wreg;
    logic        rw;
    logic        zero;
  } instr_t;

  typedef struct {
    instr_t in;
    logic   exp_pc;
    logic   exp_wbv;
  } vec_t;

  typedef struct {
    logic [4:0]  wreg;
    logic        rw;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        is_load;
  } wb_exp_t;

  logic        clk, reset;
  logic        ex_valid, ex_zero, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch;
  logic [31:0] ex_alu_result, ex_write_data, ex_branch_target;
  logic [4:0]  ex_write_reg;
  logic        flush, stall, dm_req, dm_we, dm_ack, pc_src;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, branch_target;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_alu_result, wb_read_data;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int tests = 0;
  int fails = 0;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_zero(ex_zero),
    .ex_write_data(ex_write_data), .ex_write_reg(ex_write_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_branch_target(ex_branch_target), .flush(flush), .stall(stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .pc_src(pc_src), .branch_target(branch_target),
`ifdef MEM_ALIGN_CHECK_EN
    .misaligned(misaligned),
`endif
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_write_reg(wb_write_reg), .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t mk(input logic [1:0] kind, input logic [31:0] alu, wdata,
                                input logic [4:0] wreg, input logic rw, zero,
                                input logic [31:0] tgt, input logic fl);
    instr_t r;
    r.live = 1'b1; r.valid = 1'b1; r.flush = fl; r.kind = kind; r.alu = alu;
    r.wdata = wdata; r.tgt = tgt; r.wreg = wreg; r.rw = rw; r.zero = zero;
    return r;
  endfunction

  function automatic instr_t bubble();
    instr_t r;
    r = mk(K_ALU, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    r.live = 1'b0; r.valid = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h111;
  endfunction

  task automatic apply(input instr_t in);
    ex_valid         = in.valid;
    flush            = in.flush;
    ex_alu_result    = in.alu;
    ex_zero          = in.zero;
    ex_write_data    = in.wdata;
    ex_write_reg     = in.wreg;
    ex_reg_write     = in.rw;
    ex_mem_to_reg    = (in.kind == K_LD);
    ex_mem_read      = (in.kind == K_LD);
    ex_mem_write     = (in.kind == K_ST);
    ex_branch        = (in.kind == K_BR);
    ex_branch_target = in.tgt;
  endtask

  // Memory instruction acked after nwait wait cycles, followed by an ALU op
  // that is held (with flush raised while stalled) and must still retire.
  task automatic do_mem(input string nm, input logic [31:0] addr, wdata, input logic st,
                        input int nwait, input logic [31:0] rdata);
    int req_n, stall_n;
    instr_t nxt;
    req_n = 0; stall_n = 0;
    apply(mk(st ? K_ST : K_LD, addr, wdata, 5'd12, ~st, 1'b0, 32'd0, 1'b0));
    tick();
    nxt = mk(K_ALU, 32'h77, 32'd0, 5'd9, 1'b1, 1'b0, 32'd0, nwait > 0);
    apply(nxt);
    for (int c = 0; c <= nwait; c++) begin
      if (c == nwait) begin dm_ack = 1'b1; dm_rdata = rdata; flush = 1'b0; end
      @(negedge clk);
      req_n += int'(dm_req);
      stall_n += int'(stall);
      chk({nm, " dm_addr"}, dm_addr, addr);
      chk1({nm, " dm_we"}, dm_we, st);
      if (st) chk({nm, " dm_wdata"}, dm_wdata, wdata);
      if (c < nwait) chk1({nm, " wb_valid while waiting"}, wb_valid, 1'b0);
      tick();
    end
    dm_ack = 1'b0; dm_rdata = 32'd0;
    apply(bubble());
    chk({nm, " request cycles"}, 32'(req_n), 32'(nwait + 1));
    chk({nm, " stall cycles"}, 32'(stall_n), 32'(nwait));
    @(negedge clk);
    chk1({nm, " wb_valid"}, wb_valid, 1'b1);
    chk1({nm, " wb_reg_write"}, wb_reg_write, ~st);
    chk({nm, " wb_write_reg"}, 32'(wb_write_reg), 32'd12);
    chk({nm, " wb_alu_result"}, wb_alu_result, addr);
    if (!st) chk({nm, " wb_read_data"}, wb_read_data, rdata);
    chk1({nm, " dm_req after ack"}, dm_req, 1'b0);
    tick();
    @(negedge clk);
    chk1({nm, " follow wb_valid"}, wb_valid, 1'b1);
    chk({nm, " follow wb_write_reg"}, 32'(wb_write_reg), 32'd9);
    chk({nm, " follow wb_alu_result"}, wb_alu_result, 32'h77);
    tick();
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    r.live  = 1'b1;
    r.valid = ($urandom_range(7) != 0);
    r.flush = ($urandom_range(7) == 0);
    r.kind  = 2'($urandom_range(3));
    r.alu   = (r.kind == K_LD || r.kind == K_ST) ? (32'($urandom_range(15)) << 2) : $urandom;
    r.wdata = $urandom;
    r.tgt   = $urandom;
    r.wreg  = 5'($urandom_range(31));
    r.rw    = 1'($urandom_range(1));
    r.zero  = 1'($urandom_range(1));
    return r;
  endfunction

  vec_t        tbl[7];
  instr_t      cur, in_mem;
  wb_exp_t     q[$];
  wb_exp_t     e;
  logic [31:0] ref_mem[16];
  logic [31:0] phys_mem[16];

  initial begin
    reset = 1'b1;
    apply(bubble());
    dm_ack = 1'b0; dm_rdata = 32'd0;
    #3;
    chk1("reset stall", stall, 1'b0);
    chk1("reset dm_req", dm_req, 1'b0);
    chk1("reset pc_src", pc_src, 1'b0);
    chk1("reset wb_valid", wb_valid, 1'b0);
    chk("reset dm_addr", dm_addr, 32'd0);
    chk("reset wb_alu_result", wb_alu_result, 32'd0);
    tick(); tick();
    reset = 1'b0;

    // in, exp_pc_src, exp_wb_valid
    tbl[0] = '{mk(K_ALU, 32'h10,        0, 5'd5,  1, 0, 0,          0), 1'b0, 1'b1};
    tbl[1] = '{mk(K_ALU, 32'hFFFF_FFFF, 0, 5'd31, 1, 0, 0,          0), 1'b0, 1'b1};
    tbl[2] = '{mk(K_ALU, 32'h0,         0, 5'd3,  1, 1, 32'h300,    0), 1'b0, 1'b1};
    tbl[3] = '{mk(K_BR,  32'h0,         0, 5'd0,  0, 1, 32'h200,    0), 1'b1, 1'b1};
    tbl[4] = '{mk(K_BR,  32'h4,         0, 5'd0,  0, 0, 32'h200,    0), 1'b0, 1'b1};
    tbl[5] = '{mk(K_ALU, 32'h55,        0, 5'd8,  1, 0, 0,          1), 1'b0, 1'b0};
    tbl[6] = '{mk(K_BR,  32'h0,         0, 5'd0,  0, 1, 32'h400,    1), 1'b0, 1'b0};

    for (int i = 0; i < 7; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      apply(tbl[i].in);
      tick();
      apply(bubble());
      @(negedge clk);
      chk1({nm, " pc_src"}, pc_src, tbl[i].exp_pc);
      if (tbl[i].exp_pc) chk({nm, " branch_target"}, branch_target, tbl[i].in.tgt);
      chk1({nm, " stall"}, stall, 1'b0);
      chk1({nm, " dm_req"}, dm_req, 1'b0);
      tick();
      @(negedge clk);
      chk1({nm, " pc_src gone"}, pc_src, 1'b0);
      chk1({nm, " wb_valid"}, wb_valid, tbl[i].exp_wbv);
      if (tbl[i].exp_wbv) begin
        chk({nm, " wb_alu_result"}, wb_alu_result, tbl[i].in.alu);
        chk({nm, " wb_write_reg"}, 32'(wb_write_reg), 32'(tbl[i].in.wreg));
        chk1({nm, " wb_reg_write"}, wb_reg_write, tbl[i].in.rw);
      end
      tick();
      @(negedge clk);
      chk1({nm, " wb_valid one cycle"}, wb_valid, 1'b0);
      tick();
    end

    do_mem("ld40", 32'h40, 32'd0, 1'b0, 2, 32'hDEAD_BEEF);
    do_mem("st80", 32'h80, 32'h1234, 1'b1, 0, 32'd0);
    do_mem("ld48", 32'h48, 32'd0, 1'b0, 0, 32'h0BAD_F00D);

    // flushed load never reaches memory
    apply(mk(K_LD, 32'h60, 32'd0, 5'd4, 1'b1, 1'b0, 32'd0, 1'b1));
    tick();
    apply(bubble());
    dm_ack = 1'b1;  // ack while IDLE must be ignored
    @(negedge clk);
    chk1("flush dm_req", dm_req, 1'b0);
    chk1("flush stall", stall, 1'b0);
    tick();
    dm_ack = 1'b0;
    @(negedge clk);
    chk1("flush wb_valid", wb_valid, 1'b0);
    tick();

`ifdef MEM_ALIGN_CHECK_EN
    apply(mk(K_LD, 32'h42, 32'd0, 5'd6, 1'b1, 1'b0, 32'd0, 1'b0));
    tick();
    apply(bubble());
    @(negedge clk);
    chk1("misal dm_req", dm_req, 1'b0);
    chk1("misal misaligned", misaligned, 1'b1);
    tick();
    @(negedge clk);
    chk1("misal pulse end", misaligned, 1'b0);
    chk1("misal wb_valid", wb_valid, 1'b1);
    chk1("misal wb_reg_write", wb_reg_write, 1'b0);
    tick();
`endif

    // reset in the second request cycle of a pending load
    apply(mk(K_LD, 32'h50, 32'd0, 5'd7, 1'b1, 1'b0, 32'd0, 1'b0));
    tick();
    apply(bubble());
    @(negedge clk);
    chk1("rstmid dm_req before", dm_req, 1'b1);
    tick();
    #2 reset = 1'b1;
    #1;
    chk1("rstmid dm_req", dm_req, 1'b0);
    chk1("rstmid stall", stall, 1'b0);
    chk1("rstmid dm_we", dm_we, 1'b0);
    chk("rstmid dm_addr", dm_addr, 32'd0);
    chk1("rstmid wb_valid", wb_valid, 1'b0);
    chk1("rstmid pc_src", pc_src, 1'b0);
    tick();
    reset = 1'b0;
    do_mem("ld44", 32'h44, 32'd0, 1'b0, 1, 32'hCAFE_0044);

    // randomized stream against program-order model
    begin
      bit have_cur;
      int issued, latched, idx, cyc;
      for (int i = 0; i < 16; i++) begin
        ref_mem[i] = init_word(i);
        phys_mem[i] = init_word(i);
      end
      in_mem = bubble();
      have_cur = 1'b0; issued = 0; latched = 0;
      for (cyc = 0; cyc < 6000; cyc++) begin
        if (latched == NRAND && q.size() == 0) break;
        if (!have_cur) begin
          if (issued < NRAND) begin cur = rand_instr(); issued++; end
          else cur = bubble();
          have_cur = 1'b1;
          apply(cur);
        end
        if (dm_req) begin
          if ($urandom_range(2) == 0) begin
            dm_ack = 1'b1;
            idx = int'(dm_addr[5:2]);
            if (dm_we) begin phys_mem[idx] = dm_wdata; dm_rdata = $urandom; end
            else dm_rdata = phys_mem[idx];
          end else begin
            dm_ack = 1'b0; dm_rdata = $urandom;
          end
        end else begin
          dm_ack = 1'($urandom_range(1)); dm_rdata = $urandom;
        end
        @(negedge clk);
        chk1("rand pc_src", pc_src,
             in_mem.valid & ~in_mem.flush & (in_mem.kind == K_BR) & in_mem.zero);
        if (in_mem.valid && !in_mem.flush && in_mem.kind == K_BR && in_mem.zero)
          chk("rand branch_target", branch_target, in_mem.tgt);
        if (wb_valid) begin
          if (q.size() == 0) chk1("rand unexpected wb_valid", wb_valid, 1'b0);
          else begin
            e = q.pop_front();
            chk("rand wb_write_reg", 32'(wb_write_reg), 32'(e.wreg));
            chk1("rand wb_reg_write", wb_reg_write, e.rw);
            chk1("rand wb_mem_to_reg", wb_mem_to_reg, e.m2r);
            chk("rand wb_alu_result", wb_alu_result, e.alu);
            if (e.is_load) chk("rand wb_read_data", wb_read_data, e.rdata);
          end
        end
        if (!stall) begin
          in_mem = cur;
          if (cur.valid && !cur.flush) begin
            idx = int'(cur.alu[5:2]);
            e.wreg = cur.wreg;
            e.rw = cur.rw & (cur.kind != K_ST);
            e.m2r = (cur.kind == K_LD);
            e.alu = cur.alu;
            e.is_load = (cur.kind == K_LD);
            e.rdata = ref_mem[idx];
            if (cur.kind == K_ST) ref_mem[idx] = cur.wdata;
            q.push_back(e);
          end
          if (cur.live) latched++;
          have_cur = 1'b0;
        end
        tick();
      end
      dm_ack = 1'b0;
      chk("rand instructions latched", 32'(latched), 32'(NRAND));
      chk("rand wb entries outstanding", 32'(q.size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
